// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter onto a simple dual-port buffer
// (writes to port A, registered reads on port B).
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             mem_enA,
  output logic             mem_weA,
  output logic [AW-1:0]    mem_addrA,
  output logic [WIDTH-1:0] mem_dinA,
  output logic             mem_enB,
  output logic [AW-1:0]    mem_addrB,
  input  logic [WIDTH-1:0] mem_doutB,
  output logic             busy
);
  logic wr_last, rd_last, rsp_v, rsp_idx;
  logic w0, w1, r0, r1, wg0, wg1, rg0, rg1;
  // On conflict the requester that was not granted last wins; a lone contender always wins.
  always_comb begin
    w0 = req0_valid & req0_we;
    w1 = req1_valid & req1_we;
    r0 = req0_valid & ~req0_we;
    r1 = req1_valid & ~req1_we;
    wg0 = ~rst & w0 & (~w1 | wr_last);
    wg1 = ~rst & w1 & (~w0 | ~wr_last);
    rg0 = ~rst & r0 & (~r1 | rd_last);
    rg1 = ~rst & r1 & (~r0 | ~rd_last);
    req0_ready = wg0 | rg0;
    req1_ready = wg1 | rg1;
    mem_enA = wg0 | wg1;
    mem_weA = wg0 | wg1;
    mem_addrA = wg1 ? req1_addr : req0_addr;
    mem_dinA = wg1 ? req1_wdata : req0_wdata;
    mem_enB = rg0 | rg1;
    mem_addrB = rg1 ? req1_addr : req0_addr;
    rsp0_valid = rsp_v & ~rsp_idx;
    rsp1_valid = rsp_v & rsp_idx;
    rsp_rdata = mem_doutB;
    busy = rsp_v | req0_valid | req1_valid;
  end
  always_ff @(posedge clkA) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
      rsp_v <= 1'b0;
      rsp_idx <= 1'b0;
    end else begin
      if (mem_enA) wr_last <= wg1;
      if (mem_enB) rd_last <= rg1;
      rsp_v <= mem_enB;
      rsp_idx <= rg1;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the matrix-multiply local buffer (simple dual-port RAM: write port A, registered read port B). Each requester issues read or write requests through a valid/ready handshake. Writes are routed to port A, reads to port B, and each port has its own round-robin arbitration. Read data returns one cycle after grant with a per-requester valid. The block sits between the load/compute engines and one buffer instance, with the buffer's clkB tied to clkA.

## Interface
- WIDTH, 32, data width; must match the buffer.
- DEPTH, 512, buffer depth in words; address width AW = $clog2(DEPTH).
- clkA  in  1  clock for the block and both buffer ports.
- rst  in  1  reset, synchronous, active-high.
- req0_valid, req1_valid  in  1 each  request present.
- req0_we, req1_we  in  1 each  1 = write, 0 = read.
- req0_addr, req1_addr  in  AW each  word address.
- req0_wdata, req1_wdata  in  WIDTH each  write data.
- req0_ready, req1_ready  out  1 each  grant; the request is consumed on a cycle where valid & ready.
- rsp0_valid, rsp1_valid  out  1 each  read data valid for that requester.
- rsp_rdata  out  WIDTH  read data, shared; qualified by rspN_valid.
- mem_enA, mem_weA  out  1 each  buffer port A enable / write enable.
- mem_addrA  out  AW  port A address.
- mem_dinA  out  WIDTH  port A write data.
- mem_enB  out  1  port B enable.
- mem_addrB  out  AW  port B address.
- mem_doutB  in  WIDTH  buffer registered read data.
- busy  out  1  a read is in flight (rsp pipeline non-empty) or any req valid.

## Operation
- Port classes:
  - A request with we=1 competes for the write port.
  - A request with we=0 competes for the read port.
  - The two ports arbitrate independently in the same cycle. Req0 writing while req1 reads grants both.
- Round-robin per port:
  - Registers wr_last and rd_last hold the index of the last granted requester on that port.
  - On conflict, the requester ≠ last wins.
  - With a single contender, that contender wins regardless of the pointer.
  - The pointer updates only on a grant.
  - Reset value is 1 for both pointers, so requester 0 wins the first conflict.
- Grant logic is combinational from valid/we/pointer. Ready depends only on the current cycle's inputs; it never depends on a previous ready.
- Write grant:
  - mem_enA = mem_weA = 1.
  - mem_addrA and mem_dinA are muxed from the granted requester.
- Read grant:
  - mem_enB = 1 and mem_addrB is muxed from the granted requester.
  - Register rsp_sel (valid bit plus requester index) captures the grant.
- Response:
  - rspN_valid = rsp_sel.valid & (rsp_sel.idx == N).
  - rsp_rdata = mem_doutB passed straight through.
- While rst=1:
  - All ready outputs, mem_enA, mem_weA and mem_enB are 0.
  - No pointer update.
- Idle port outputs: when not granted, address/data outputs are don't-care. mem_enA, mem_weA and mem_enB must be 0.

## Timing
- Reset values (register state after any clock edge with rst=1):
  - rsp0_valid = rsp1_valid = 0.
  - wr_last = rd_last = 1.
  - busy = 0 if no req valid.
- Write latency: the write is committed at the clkA edge ending the grant cycle.
- Read latency: grant in cycle N gives rspN_valid=1 in cycle N+1, with data equal to the buffer word at the end of cycle N.
- Throughput: one read and one write per cycle sustained. Back-to-back reads produce back-to-back responses.
- No response backpressure: requesters must always accept rsp.
- Same-address read and write granted in the same cycle: the read returns the OLD data.
- Write in cycle N followed by a read in N+1: the read returns the NEW data.
- Reset mid-operation:
  - A read granted in cycle N with rst=1 in N+1 still shows rsp valid in N+1, because rsp_sel was captured at the edge ending N.
  - rsp_sel is cleared at the edge ending N+1.
  - The buffer's doutB is also cleared by rst at that edge. Responses never cross a reset cycle.
- Requester holding valid while not ready must keep addr/we/wdata stable. The arbiter does not check this.

## Test plan
- Single write then read: req0 write addr 5 data 0xDEADBEEF, then req0 read addr 5 -> ready both cycles; rsp0_valid one cycle later with rsp_rdata=0xDEADBEEF; rsp1_valid stays 0.
- Write conflict round-robin: both requesters write every cycle for 4 cycles (req0 to 10..13, req1 to 20..23) -> grants alternate 0,1,0,1 starting with req0; each requester completes in order; final reads confirm all 4 granted words.
- Read/write concurrency: req0 writes 0x1 to addr 7 while req1 reads addr 7 in the same cycle (prior value 0x0) -> both ready; rsp1 returns 0x0. Next-cycle read of addr 7 returns 0x1.
- Back-to-back reads: req1 reads addr 0..7 on consecutive cycles with no contention -> ready every cycle; rsp1_valid high 8 consecutive cycles starting one cycle after the first grant; data in address order.
- Reset mid-operation: assert rst in the cycle after a read grant and hold for 2 cycles with valid requests present -> the in-flight response appears once; all readies and enables are 0 during reset; the first post-reset conflict is granted to req0.
- Single contender with pointer favoring it: req1 granted alone, then req1 alone again -> granted both times with no bubble.
